// File: rtl/star_row_accumulator_pkg.sv
// Shared types for the softmax row accumulator: Q9.17 lane/vector types, widened
// accumulator types, Q9.17 saturation limits and the row FSM encoding.
package star_row_accumulator_pkg;

  localparam int unsigned MAX_EMBEDDING_DIM = 4;
  localparam int unsigned STAR_LANES        = MAX_EMBEDDING_DIM + 1;
  localparam int unsigned STAR_Q_W          = 26;
  localparam int unsigned STAR_ACC_GUARD    = 4;
  localparam int unsigned STAR_ACC_W        = STAR_Q_W + STAR_ACC_GUARD;

  typedef logic signed [STAR_Q_W-1:0]   STAR_QT;
  typedef STAR_QT [MAX_EMBEDDING_DIM:0] STAR_VECTOR_T;

  typedef logic signed [STAR_ACC_W-1:0]     STAR_ACC_QT;
  typedef STAR_ACC_QT [MAX_EMBEDDING_DIM:0] STAR_ACC_VECTOR_T;

  localparam STAR_QT STAR_Q_MAX = 26'sh1FFFFFF;
  localparam STAR_QT STAR_Q_MIN = 26'sh2000000;

  typedef enum logic {
    ROW_EMPTY = 1'b0,
    ROW_ACCUM = 1'b1
  } row_state_t;

endpackage

// File: rtl/star_acc_lane.sv
// One accumulator lane: load-or-add, Q9.17 narrowing and overflow flag (combinational).
// STAR_ACC_SAT_EN selects saturating add/narrowing; otherwise wrap and truncate.
module star_acc_lane
  import star_row_accumulator_pkg::*;
#(
  parameter int unsigned ACC_W = STAR_ACC_W
) (
  input  logic                load,
  input  logic [ACC_W-1:0]    acc,
  input  logic [STAR_Q_W-1:0] v,
  output logic [ACC_W-1:0]    acc_next,
  output logic [STAR_Q_W-1:0] narrow,
  output logic                ovf
);

  logic [ACC_W-1:0] v_ext;

  assign v_ext = {{(ACC_W - STAR_Q_W){v[STAR_Q_W-1]}}, v};

`ifdef STAR_ACC_SAT_EN
  logic [ACC_W:0]          wide;
  logic [ACC_W-STAR_Q_W:0] upper;
  logic                    add_ovf;
  logic                    narrow_ovf;

  always_comb begin
    wide       = {acc[ACC_W-1], acc} + {v_ext[ACC_W-1], v_ext};
    add_ovf    = 1'b0;
    acc_next   = wide[ACC_W-1:0];
    if (load) begin
      acc_next = v_ext;
    end else if (wide[ACC_W] != wide[ACC_W-1]) begin
      add_ovf  = 1'b1;
      acc_next = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
    // Value fits Q9.17 only when every bit above the Q9.17 sign bit matches it.
    upper      = acc_next[ACC_W-1:STAR_Q_W-1];
    narrow_ovf = !((&upper) || !(|upper));
    narrow     = acc_next[STAR_Q_W-1:0];
    if (narrow_ovf) narrow = acc_next[ACC_W-1] ? STAR_Q_MIN : STAR_Q_MAX;
    ovf        = add_ovf | narrow_ovf;
  end
`else
  always_comb begin
    acc_next = load ? v_ext : acc + v_ext;
    narrow   = acc_next[STAR_Q_W-1:0];
    ovf      = 1'b0;
  end
`endif

endmodule

// File: rtl/star_row_accumulator.sv
// Sums exp-scaled value vectors lane-wise over a query row and hands the narrowed
// Q9.17 row sum to the normalizer. Optional saturation via STAR_ACC_SAT_EN.
module star_row_accumulator
  import star_row_accumulator_pkg::*;
#(
  parameter int unsigned ACC_GUARD = STAR_ACC_GUARD,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_in,
  output logic             rdy_out,
  input  logic             last_in,
  input  STAR_VECTOR_T     v_in,
  output logic             vld_out,
  input  logic             rdy_in,
  output STAR_VECTOR_T     sum_out,
  output logic [CNT_W-1:0] beats_out,
  output logic             ovf_out
);

  localparam int unsigned ACC_W = STAR_Q_W + ACC_GUARD;

  row_state_t            state;
  logic                  out_full;
  logic [ACC_W-1:0]      acc      [STAR_LANES];
  logic [ACC_W-1:0]      acc_next [STAR_LANES];
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic                  ovf_row;
  logic                  ovf_next;
  logic [STAR_LANES-1:0] lane_ovf;
  STAR_VECTOR_T          narrow;
  logic                  first;
  logic                  accept;

  assign first   = (state == ROW_EMPTY);
  assign rdy_out = !out_full || rdy_in;
  assign accept  = vld_in && rdy_out;
  assign vld_out = out_full;

  for (genvar i = 0; i < STAR_LANES; i++) begin : g_lane
    star_acc_lane #(.ACC_W(ACC_W)) u_lane (
      .load     (first),
      .acc      (acc[i]),
      .v        (v_in[i]),
      .acc_next (acc_next[i]),
      .narrow   (narrow[i]),
      .ovf      (lane_ovf[i])
    );
  end

  always_comb begin
    cnt_next = CNT_W'(1);
    ovf_next = |lane_ovf;
    if (!first) begin
      cnt_next = (cnt == '1) ? cnt : cnt + 1'b1;
      ovf_next = ovf_row | (|lane_ovf);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ROW_EMPTY;
      out_full  <= 1'b0;
      cnt       <= '0;
      ovf_row   <= 1'b0;
      sum_out   <= '0;
      beats_out <= '0;
      ovf_out   <= 1'b0;
      for (int unsigned i = 0; i < STAR_LANES; i++) acc[i] <= '0;
    end else begin
      if (out_full && rdy_in) out_full <= 1'b0;
      if (accept) begin
        for (int unsigned i = 0; i < STAR_LANES; i++) acc[i] <= acc_next[i];
        cnt     <= cnt_next;
        ovf_row <= ovf_next;
        // A last beat reloads the output register, overriding the drain above.
        if (last_in) begin
          sum_out   <= narrow;
          beats_out <= cnt_next;
          ovf_out   <= ovf_next;
          out_full  <= 1'b1;
          state     <= ROW_EMPTY;
        end else begin
          state     <= ROW_ACCUM;
        end
      end
    end
  end

endmodule

// File: tb/tb_star_row_accumulator.sv
// Self-checking bench for star_row_accumulator; honours STAR_ACC_SAT_EN when defined.
module tb_star_row_accumulator;
  import star_row_accumulator_pkg::*;

  localparam int unsigned NL    = MAX_EMBEDDING_DIM + 1;
  localparam int unsigned CNT_W = 8;
`ifdef STAR_ACC_SAT_EN
  localparam longint ACC_HI = (longint'(1) << 29) - 1;
  localparam longint ACC_LO = -(longint'(1) << 29);
  localparam longint Q_HI   = (longint'(1) << 25) - 1;
  localparam longint Q_LO   = -(longint'(1) << 25);
`endif

  typedef struct packed {
    STAR_VECTOR_T sum;
    logic [7:0]   beats;
    logic         ovf;
  } result_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             vld_in;
  logic             rdy_out;
  logic             last_in;
  STAR_VECTOR_T     v_in;
  logic             vld_out;
  logic             rdy_in;
  STAR_VECTOR_T     sum_out;
  logic [CNT_W-1:0] beats_out;
  logic             ovf_out;

  int      checks = 0;
  int      passed = 0;
  int      cyc    = 0;
  result_t cap;
  result_t got_q[$];
  int      got_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  star_row_accumulator #(.ACC_GUARD(4), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .vld_in    (vld_in),
    .rdy_out   (rdy_out),
    .last_in   (last_in),
    .v_in      (v_in),
    .vld_out   (vld_out),
    .rdy_in    (rdy_in),
    .sum_out   (sum_out),
    .beats_out (beats_out),
    .ovf_out   (ovf_out)
  );

  // Record every row sum taken by the downstream side (transfer at the next posedge).
  always @(negedge clk) begin
    if (!rst && vld_out && rdy_in) begin
      cap.sum   = sum_out;
      cap.beats = beats_out;
      cap.ovf   = ovf_out;
      got_q.push_back(cap);
      got_cyc.push_back(cyc);
    end
  end

  function automatic STAR_VECTOR_T fill(input int val);
    STAR_VECTOR_T f;
    for (int l = 0; l < NL; l++) f[l] = STAR_QT'(val);
    return f;
  endfunction

  function automatic STAR_VECTOR_T rand_vec(input int bits);
    STAR_VECTOR_T f;
    int r;
    for (int l = 0; l < NL; l++) begin
      r = int'($urandom_range(0, (1 << bits) - 1)) - (1 << (bits - 1));
      f[l] = STAR_QT'(r);
    end
    return f;
  endfunction

  // Reference: exact lane sums in 64-bit arithmetic, clamped or wrapped by the configured rules.
  function automatic result_t model_row(input STAR_VECTOR_T beats[$]);
    result_t      r;
    STAR_VECTOR_T vec;
    longint       acc;
    longint       x;
    r.ovf   = 1'b0;
    r.beats = (beats.size() > 255) ? 8'd255 : 8'(beats.size());
    r.sum   = '0;
    for (int l = 0; l < NL; l++) begin
      acc = 0;
      for (int b = 0; b < beats.size(); b++) begin
        vec = beats[b];
        x   = longint'($signed(vec[l]));
        acc = acc + x;
`ifdef STAR_ACC_SAT_EN
        if (acc > ACC_HI) begin acc = ACC_HI; r.ovf = 1'b1; end
        else if (acc < ACC_LO) begin acc = ACC_LO; r.ovf = 1'b1; end
`endif
      end
`ifdef STAR_ACC_SAT_EN
      if (acc > Q_HI) begin acc = Q_HI; r.ovf = 1'b1; end
      else if (acc < Q_LO) begin acc = Q_LO; r.ovf = 1'b1; end
`endif
      r.sum[l] = acc[25:0];
    end
    return r;
  endfunction

  task automatic send_beat(input STAR_VECTOR_T v, input logic last);
    int unsigned waited = 0;
    vld_in = 1'b1; v_in = v; last_in = last;
    @(negedge clk);
    while (rdy_out !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (rdy_out !== 1'b1) begin
      checks++;
      $display("FAIL beat_accept_timeout: rdy_out=%b after %0d cycles, required 1", rdy_out, waited);
    end
    @(posedge clk); #1;
    vld_in = 1'b0; last_in = 1'b0;
  endtask

  task automatic wait_results(input int n);
    for (int c = 0; c < 400 && got_q.size() < n; c++) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; vld_in = 1'b0; last_in = 1'b0; v_in = '0; rdy_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (vld_out !== 1'b0) $display("FAIL reset_vld: got %b want 0", vld_out); else passed++;
    checks++; if (sum_out !== '0) $display("FAIL reset_sum: got %h want 0", sum_out); else passed++;
    checks++; if (beats_out !== '0) $display("FAIL reset_beats: got %0d want 0", beats_out); else passed++;
    checks++; if (ovf_out !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf_out); else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (rdy_out !== 1'b1) $display("FAIL reset_rdy: got %b want 1", rdy_out); else passed++;
    rdy_in = 1'b1;
  endtask

  task automatic test_three_beat();
    STAR_VECTOR_T row[$];
    result_t      exp_r;
    got_q.delete(); got_cyc.delete();
    rdy_in = 1'b1;
    row.push_back(fill(131072)); row.push_back(fill(65536)); row.push_back(fill(32768));
    send_beat(row[0], 1'b0);
    send_beat(row[1], 1'b0);
    checks++; if (vld_out !== 1'b0) $display("FAIL three_early_vld: got %b want 0", vld_out); else passed++;
    send_beat(row[2], 1'b1);
    checks++; if (vld_out !== 1'b1) $display("FAIL three_latency: got %b want 1", vld_out); else passed++;
    wait_results(1);
    checks++; if (got_q.size() !== 1) $display("FAIL three_count: got %0d want 1", got_q.size()); else passed++;
    if (got_q.size() >= 1) begin
      exp_r = model_row(row);
      checks++;
      if (got_q[0].sum !== fill(229376) || got_q[0].beats !== 8'd3)
        $display("FAIL three_sum: got %h/%0d want %h/3", got_q[0].sum, got_q[0].beats, fill(229376));
      else passed++;
      checks++;
      if (got_q[0] !== exp_r) $display("FAIL three_model: got %h want %h", got_q[0], exp_r); else passed++;
    end
  endtask

  task automatic test_single_neg();
    STAR_VECTOR_T row[$];
    STAR_VECTOR_T v;
    result_t      exp_r;
    got_q.delete(); got_cyc.delete();
    v = rand_vec(20);
    v[0] = STAR_QT'(-262144);
    row.push_back(v);
    send_beat(v, 1'b1);
    wait_results(1);
    checks++; if (got_q.size() !== 1) $display("FAIL single_count: got %0d want 1", got_q.size()); else passed++;
    if (got_q.size() >= 1) begin
      exp_r = model_row(row);
      checks++;
      if (got_q[0].sum[0] !== STAR_QT'(-262144) || got_q[0].beats !== 8'd1)
        $display("FAIL single_lane0: got %h/%0d want %h/1", got_q[0].sum[0], got_q[0].beats, STAR_QT'(-262144));
      else passed++;
      checks++;
      if (got_q[0] !== exp_r) $display("FAIL single_model: got %h want %h", got_q[0], exp_r); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    STAR_VECTOR_T a[$];
    STAR_VECTOR_T b[$];
    STAR_VECTOR_T beats[4];
    result_t      exp_a;
    result_t      exp_b;
    got_q.delete(); got_cyc.delete();
    rdy_in = 1'b1;
    for (int i = 0; i < 4; i++) beats[i] = rand_vec(24);
    a.push_back(beats[0]); a.push_back(beats[1]);
    b.push_back(beats[2]); b.push_back(beats[3]);
    exp_a = model_row(a);
    exp_b = model_row(b);
    for (int i = 0; i < 4; i++) begin
      vld_in = 1'b1; v_in = beats[i]; last_in = (i % 2 == 1);
      @(negedge clk);
      checks++; if (rdy_out !== 1'b1) $display("FAIL b2b_rdy beat %0d: got %b want 1", i, rdy_out); else passed++;
      @(posedge clk); #1;
    end
    vld_in = 1'b0; last_in = 1'b0;
    wait_results(2);
    checks++; if (got_q.size() !== 2) $display("FAIL b2b_count: got %0d want 2", got_q.size()); else passed++;
    if (got_q.size() >= 2) begin
      checks++; if (got_q[0] !== exp_a) $display("FAIL b2b_row_a: got %h want %h", got_q[0], exp_a); else passed++;
      checks++; if (got_q[1] !== exp_b) $display("FAIL b2b_row_b: got %h want %h", got_q[1], exp_b); else passed++;
      checks++;
      if (got_cyc[1] - got_cyc[0] !== 2) $display("FAIL b2b_spacing: got %0d want 2", got_cyc[1] - got_cyc[0]);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    STAR_VECTOR_T a[$];
    STAR_VECTOR_T b[$];
    result_t      exp_a;
    result_t      exp_b;
    got_q.delete(); got_cyc.delete();
    rdy_in = 1'b0;
    a.push_back(rand_vec(24)); a.push_back(rand_vec(24));
    b.push_back(rand_vec(24)); b.push_back(rand_vec(24));
    exp_a = model_row(a);
    exp_b = model_row(b);
    send_beat(a[0], 1'b0);
    send_beat(a[1], 1'b1);
    vld_in = 1'b1; v_in = b[0]; last_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (rdy_out !== 1'b0) $display("FAIL bp_stall cyc %0d: got %b want 0", i, rdy_out); else passed++;
      checks++;
      if (sum_out !== exp_a.sum || beats_out !== exp_a.beats)
        $display("FAIL bp_hold cyc %0d: got %h/%0d want %h/%0d", i, sum_out, beats_out, exp_a.sum, exp_a.beats);
      else passed++;
      @(posedge clk); #1;
    end
    rdy_in = 1'b1;
    send_beat(b[0], 1'b0);
    send_beat(b[1], 1'b1);
    wait_results(2);
    checks++; if (got_q.size() !== 2) $display("FAIL bp_count: got %0d want 2", got_q.size()); else passed++;
    if (got_q.size() >= 2) begin
      checks++; if (got_q[0] !== exp_a) $display("FAIL bp_row_a: got %h want %h", got_q[0], exp_a); else passed++;
      checks++; if (got_q[1] !== exp_b) $display("FAIL bp_row_b: got %h want %h", got_q[1], exp_b); else passed++;
    end
  endtask

  task automatic test_saturation();
    STAR_VECTOR_T r1[$];
    STAR_VECTOR_T r2[$];
    STAR_VECTOR_T r3[$];
    STAR_VECTOR_T v;
    STAR_QT       want0;
    logic         want_ovf;
    result_t      exp_r;
    got_q.delete(); got_cyc.delete();
    rdy_in = 1'b1;
`ifdef STAR_ACC_SAT_EN
    want0 = 26'h1FFFFFF; want_ovf = 1'b1;
`else
    want0 = 26'h3E00000; want_ovf = 1'b0;
`endif
    v = fill(32'h1FE0000);
    v[1] = STAR_QT'(-32'sh1FE0000);
    for (int i = 0; i < 16; i++) r1.push_back(v);
    v = fill(32'h1FFFFFF);
    v[2] = STAR_QT'(-32'sh2000000);
    for (int i = 0; i < 20; i++) r2.push_back(v);
    r3.push_back(rand_vec(12)); r3.push_back(rand_vec(12));
    for (int i = 0; i < 16; i++) send_beat(r1[i], i == 15);
    for (int i = 0; i < 20; i++) send_beat(r2[i], i == 19);
    send_beat(r3[0], 1'b0);
    send_beat(r3[1], 1'b1);
    wait_results(3);
    checks++; if (got_q.size() !== 3) $display("FAIL sat_count: got %0d want 3", got_q.size()); else passed++;
    if (got_q.size() >= 3) begin
      checks++;
      if (got_q[0].sum[0] !== want0 || got_q[0].ovf !== want_ovf)
        $display("FAIL sat_lane0: got %h ovf %b want %h ovf %b", got_q[0].sum[0], got_q[0].ovf, want0, want_ovf);
      else passed++;
      exp_r = model_row(r1);
      checks++; if (got_q[0] !== exp_r) $display("FAIL sat_row16: got %h want %h", got_q[0], exp_r); else passed++;
      exp_r = model_row(r2);
      checks++; if (got_q[1] !== exp_r) $display("FAIL sat_row20: got %h want %h", got_q[1], exp_r); else passed++;
      exp_r = model_row(r3);
      checks++; if (got_q[2] !== exp_r) $display("FAIL sat_ovf_clear: got %h want %h", got_q[2], exp_r); else passed++;
    end
  endtask

  task automatic test_reset_mid_row();
    result_t exp_r;
    got_q.delete(); got_cyc.delete();
    rdy_in = 1'b1;
    send_beat(rand_vec(24), 1'b0);
    send_beat(rand_vec(24), 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (vld_out !== 1'b0) $display("FAIL rst_mid_vld cyc %0d: got %b want 0", i, vld_out); else passed++;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    send_beat(fill(131072), 1'b1);
    wait_results(1);
    exp_r.sum = fill(131072); exp_r.beats = 8'd1; exp_r.ovf = 1'b0;
    checks++; if (got_q.size() !== 1) $display("FAIL rst_mid_count: got %0d want 1", got_q.size()); else passed++;
    if (got_q.size() >= 1) begin
      checks++; if (got_q[0] !== exp_r) $display("FAIL rst_mid_row: got %h want %h", got_q[0], exp_r); else passed++;
    end
  endtask

  task automatic test_cnt_sat();
    STAR_VECTOR_T row[$];
    result_t      exp_r;
    got_q.delete(); got_cyc.delete();
    rdy_in = 1'b1;
    for (int i = 0; i < 300; i++) row.push_back(rand_vec(4));
    for (int i = 0; i < 300; i++) send_beat(row[i], i == 299);
    wait_results(1);
    exp_r = model_row(row);
    checks++; if (got_q.size() !== 1) $display("FAIL cnt_sat_count: got %0d want 1", got_q.size()); else passed++;
    if (got_q.size() >= 1) begin
      checks++; if (got_q[0].beats !== 8'd255) $display("FAIL cnt_sat_beats: got %0d want 255", got_q[0].beats); else passed++;
      checks++; if (got_q[0] !== exp_r) $display("FAIL cnt_sat_row: got %h want %h", got_q[0], exp_r); else passed++;
    end
  endtask

  task automatic test_random();
    result_t      exp_q[$];
    STAR_VECTOR_T row[$];
    bit           done = 1'b0;
    int           len;
    got_q.delete(); got_cyc.delete();
    fork
      begin
        for (int r = 0; r < 25; r++) begin
          row.delete();
          len = int'($urandom_range(1, 6));
          for (int i = 0; i < len; i++) row.push_back(rand_vec(($urandom_range(0, 4) == 0) ? 26 : 22));
          exp_q.push_back(model_row(row));
          for (int i = 0; i < len; i++) send_beat(row[i], i == len - 1);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          rdy_in = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
      end
    join
    rdy_in = 1'b1;
    wait_results(exp_q.size());
    checks++;
    if (got_q.size() !== exp_q.size()) $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size());
    else passed++;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++; if (got_q[k] !== exp_q[k]) $display("FAIL rand_row %0d: got %h want %h", k, got_q[k], exp_q[k]); else passed++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_three_beat();
    test_single_neg();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    test_reset_mid_row();
    test_cnt_sat();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
